// File: rtl/maxpool2d.sv
// 2x2 stride-2 max-pooling over a raster pixel stream, CH_NUM channels in
// parallel. Even-row pair maxima are parked in a one-row line buffer and
// combined with the odd-row pair when the tile's last pixel arrives.
module maxpool2d #(
  parameter int FRAME_H_MAX = 224,
  parameter int FRAME_W_MAX = 224,
  parameter int DIN_WIDTH   = 8,
  parameter int CH_NUM      = 128
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [$clog2(FRAME_H_MAX):0]         frame_h,
  input  logic [$clog2(FRAME_W_MAX):0]         frame_w,
  input  logic                                 frame_start,
  input  logic                                 din_vld,
  input  logic [CH_NUM-1:0][DIN_WIDTH-1:0]     din,
  output logic                                 dout_vld,
  output logic [CH_NUM-1:0][DIN_WIDTH-1:0]     dout,
  output logic                                 dout_last
);

  localparam int HW       = $clog2(FRAME_H_MAX) + 1;
  localparam int WW       = $clog2(FRAME_W_MAX) + 1;
  localparam int LB_DEPTH = FRAME_W_MAX / 2;
  localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef logic [CH_NUM-1:0][DIN_WIDTH-1:0] pix_t;
  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [HW-1:0]   row;
  logic [WW-1:0]   col;
  logic [HW-1:0]   cur_row;
  logic [WW-1:0]   cur_col;
  logic            accept;
  logic            col_last;
  logic            row_last;
  logic            tile_last;
  logic [AW-1:0]   lb_addr;
  pix_t            hreg;
  pix_t            lb_q;
  pix_t            max_h;
  pix_t            result;
  pix_t            linebuf [LB_DEPTH];

  // Pixel position and per-channel signed maxima for the current input beat;
  // frame_start forces the coincident pixel to (0,0).
  always_comb begin
    cur_row   = frame_start ? '0 : row;
    cur_col   = frame_start ? '0 : col;
    accept    = din_vld && (frame_start || (state == RUN));
    col_last  = (cur_col == frame_w - WW'(1));
    row_last  = (cur_row == frame_h - HW'(1));
    tile_last = (cur_row[HW-1:1] == frame_h[HW-1:1] - (HW-1)'(1)) &&
                (cur_col[WW-1:1] == frame_w[WW-1:1] - (WW-1)'(1));
    lb_addr   = cur_col[AW:1];
    max_h     = '0;
    result    = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      max_h[c]  = ($signed(hreg[c]) > $signed(din[c])) ? hreg[c] : din[c];
      result[c] = ($signed(max_h[c]) > $signed(lb_q[c])) ? max_h[c] : lb_q[c];
    end
  end

  // Datapath storage: horizontal hold register, line buffer write on even
  // rows, and line buffer prefetch on the even column of odd rows.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!cur_col[0])
        hreg <= din;
      if (cur_row[0] && !cur_col[0])
        lb_q <= linebuf[lb_addr];
      if (!cur_row[0] && cur_col[0])
        linebuf[lb_addr] <= max_h;
    end
  end

  // Frame FSM, raster counters and registered pooled output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      dout      <= '0;
    end else begin
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      if (frame_start) begin
        state <= RUN;
        row   <= '0;
        col   <= '0;
      end
      if (accept) begin
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row   <= '0;
            state <= IDLE;
          end else begin
            row <= cur_row + HW'(1);
          end
        end else begin
          col <= cur_col + WW'(1);
          row <= cur_row;
        end
        if (cur_row[0] && cur_col[0]) begin
          dout_vld  <= 1'b1;
          dout      <= result;
          dout_last <= tile_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2d.sv
// Self-checking bench for maxpool2d: frames are built in an image array,
// expected pooled pixels come from a plain 2x2-tile max over that array.
module tb_maxpool2d;

  localparam int HMAX = 16;
  localparam int WMAX = 16;
  localparam int DW   = 8;
  localparam int CH   = 2;
  localparam int HB   = $clog2(HMAX) + 1;
  localparam int WB   = $clog2(WMAX) + 1;

  typedef logic [CH-1:0][DW-1:0] pix_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [HB-1:0] frame_h;
  logic [WB-1:0] frame_w;
  logic          frame_start;
  logic          din_vld;
  pix_t          din;
  logic          dout_vld;
  pix_t          dout;
  logic          dout_last;

  maxpool2d #(
    .FRAME_H_MAX (HMAX),
    .FRAME_W_MAX (WMAX),
    .DIN_WIDTH   (DW),
    .CH_NUM      (CH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_h     (frame_h),
    .frame_w     (frame_w),
    .frame_start (frame_start),
    .din_vld     (din_vld),
    .din         (din),
    .dout_vld    (dout_vld),
    .dout        (dout),
    .dout_last   (dout_last)
  );

  always #5 clk = ~clk;

  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  pix_t img [HMAX][WMAX];
  pix_t exp_d[$];
  pix_t got_d[$];
  bit   exp_l[$];
  bit   got_l[$];
  int   exp_t[$];
  int   got_t[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Capture every output beat (or stray dout_last) with the cycle it appeared.
  always @(negedge clk) begin
    if (dout_vld === 1'b1 || dout_last === 1'b1) begin
      got_d.push_back(dout);
      got_l.push_back(dout_last === 1'b1);
      got_t.push_back(pcnt);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] smax(logic [DW-1:0] a, logic [DW-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  function automatic pix_t tile_max(int r, int c);
    pix_t m;
    for (int k = 0; k < CH; k++)
      m[k] = smax(smax(img[r][c][k], img[r][c+1][k]),
                  smax(img[r+1][c][k], img[r+1][c+1][k]));
    return m;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      frame_start = 1'b0;
      din_vld     = 1'b0;
    end
  endtask

  task automatic fill_seq(int h, int w);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        img[r][c][0] = DW'(r * w + c);
        img[r][c][1] = DW'($urandom);
      end
  endtask

  task automatic fill_rand(int h, int w);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        img[r][c] = pix_t'($urandom);
  endtask

  // Drive the first nsend raster pixels of an h x w frame; frame_start
  // coincides with pixel (0,0). Expected tiles are queued as they complete.
  task automatic send(int h, int w, int nsend, bit gaps);
    int k;
    int ho;
    int wo;
    k  = 0;
    ho = h / 2;
    wo = w / 2;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if (k < nsend) begin
          if (gaps && k > 0)
            while ($urandom_range(1) == 1) idle(1);
          @(negedge clk);
          frame_start = (k == 0);
          if (k == 0) begin
            frame_h = HB'(h);
            frame_w = WB'(w);
          end
          din_vld = 1'b1;
          din     = img[r][c];
          if ((r % 2 == 1) && (c % 2 == 1) && (r / 2 < ho) && (c / 2 < wo)) begin
            exp_d.push_back(tile_max(r - 1, c - 1));
            exp_l.push_back((r / 2 == ho - 1) && (c / 2 == wo - 1));
            exp_t.push_back(pcnt + 1);
          end
          k++;
        end
      end
  endtask

  task automatic compare(string tag, bit hold);
    int n;
    chk({tag, "_count"}, 32'(got_d.size()), 32'(exp_d.size()));
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, 32'(got_d[i]), 32'(exp_d[i]));
      chk({tag, "_last"}, 32'(got_l[i]), 32'(exp_l[i]));
      chk({tag, "_cycle"}, 32'(got_t[i]), 32'(exp_t[i]));
    end
    if (hold && exp_d.size() > 0)
      chk({tag, "_hold"}, 32'(dout), 32'(exp_d[exp_d.size() - 1]));
    exp_d.delete(); exp_l.delete(); exp_t.delete();
    got_d.delete(); got_l.delete(); got_t.delete();
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    din_vld     = 1'b0;
    din         = '0;
    frame_h     = HB'(4);
    frame_w     = WB'(4);
    idle(3);
    chk("reset_vld",  32'(dout_vld),  32'd0);
    chk("reset_last", 32'(dout_last), 32'd0);
    chk("reset_dout", 32'(dout),      32'd0);
    @(negedge clk);
    reset = 1'b0;

    // din_vld in IDLE without frame_start must be ignored
    frame_h = HB'(2);
    frame_w = WB'(2);
    repeat (6) begin
      @(negedge clk);
      din_vld = 1'b1;
      din     = pix_t'($urandom);
    end
    idle(4);
    compare("idle_ignore", 1'b0);

    // 4x4 then 5x5 back to back, sequential ch0 values
    fill_seq(4, 4);
    send(4, 4, 16, 1'b0);
    fill_seq(5, 5);
    send(5, 5, 25, 1'b0);
    idle(4);
    compare("seq", 1'b1);

    // signed extremes
    img[0][0][0] = 8'h80; img[0][1][0] = 8'hFF;
    img[1][0][0] = 8'hFB; img[1][1][0] = 8'hFE;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) img[r][c][1] = DW'($urandom);
    send(2, 2, 4, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) img[r][c] = {CH{8'h80}};
    send(2, 2, 4, 1'b0);
    idle(4);
    chk("signed_m1",   (got_d.size() > 0) ? 32'(got_d[0][0]) : 32'hFFFF_FFFF, 32'h0000_00FF);
    chk("signed_m128", (got_d.size() > 1) ? 32'(got_d[1])    : 32'hFFFF_FFFF, 32'h0000_8080);
    compare("signed", 1'b1);

    // 8x6 back to back, then the same frame with random gaps
    fill_rand(8, 6);
    send(8, 6, 48, 1'b0);
    idle(4);
    compare("b2b", 1'b1);
    send(8, 6, 48, 1'b1);
    idle(4);
    compare("gapped", 1'b1);

    // abort 6x6 at pixel (2,3) with a fresh 4x4 frame
    fill_rand(6, 6);
    send(6, 6, 15, 1'b0);
    fill_rand(4, 4);
    send(4, 4, 16, 1'b0);
    idle(4);
    compare("abort", 1'b1);

    // degenerate sizes produce nothing, then a normal frame follows
    fill_rand(5, 5);
    send(1, 5, 5, 1'b0);
    send(5, 1, 5, 1'b0);
    fill_rand(2, 2);
    send(2, 2, 4, 1'b0);
    idle(4);
    compare("degen", 1'b1);

    // reset coincident with a tile-completing pixel discards it
    fill_rand(6, 6);
    send(6, 6, 9, 1'b0);
    @(negedge clk);
    reset       = 1'b1;
    frame_start = 1'b0;
    din_vld     = 1'b1;
    din         = img[1][3];
    @(negedge clk);
    reset   = 1'b0;
    din_vld = 1'b0;
    chk("midrst_vld",  32'(dout_vld),  32'd0);
    chk("midrst_last", 32'(dout_last), 32'd0);
    chk("midrst_dout", 32'(dout),      32'd0);
    idle(3);
    compare("pre_reset", 1'b0);
    fill_rand(4, 4);
    send(4, 4, 16, 1'b0);
    idle(4);
    compare("post_reset", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
